// File: rtl/seq_alu.sv
// Sequential RV32I/M-style ALU: single-cycle integer ops, iterative multiply/divide.
// Define SEQ_ALU_MULDIV_EN to build the multiply/divide datapath; otherwise MD=1 reports ERR.
module seq_alu #(
    parameter int unsigned XLEN = 32
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [XLEN-1:0] RD1,
    input  logic [XLEN-1:0] RD2,
    input  logic [3:0]      OP,
    input  logic            MD,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [XLEN-1:0] WD,
    output logic            ERR
);
    localparam int unsigned SHW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    state_e          state_q;
    logic            valid_q;
    logic            err_q;
    logic [XLEN-1:0] wd_q;
    logic            accept_c;
    logic [XLEN-1:0] alu_res_c;
    logic            alu_err_c;
    logic [SHW-1:0]  shamt_c;

    assign IN_READY  = (state_q == S_IDLE) || ((state_q == S_DONE) && OUT_READY);
    assign accept_c  = IN_VALID && IN_READY;
    assign OUT_VALID = valid_q;
    assign WD        = wd_q;
    assign ERR       = err_q;
    assign shamt_c   = RD2[SHW-1:0];

    // Single-cycle integer ops, evaluated on the accepting edge.
    always_comb begin
        alu_res_c = '0;
        alu_err_c = 1'b0;
        case (OP)
            4'b0000: alu_res_c = RD1 + RD2;
            4'b1000: alu_res_c = RD1 - RD2;
            4'b0001: alu_res_c = RD1 << shamt_c;
            4'b0010: alu_res_c = XLEN'($signed(RD1) < $signed(RD2));
            4'b0011: alu_res_c = XLEN'(RD1 < RD2);
            4'b0100: alu_res_c = RD1 ^ RD2;
            4'b0101: alu_res_c = RD1 >> shamt_c;
            4'b1101: alu_res_c = XLEN'($signed(RD1) >>> shamt_c);
            4'b0110: alu_res_c = RD1 | RD2;
            4'b0111: alu_res_c = RD1 & RD2;
            default: alu_err_c = 1'b1;
        endcase
    end

`ifdef SEQ_ALU_MULDIV_EN
    logic [2:0]        mop_q;
    logic              neg_q;
    logic              div0_q;
    logic [XLEN-1:0]   aorig_q;
    logic [XLEN-1:0]   acc_q;
    logic [XLEN-1:0]   lo_q;
    logic [XLEN-1:0]   mcand_q;
    logic [SHW-1:0]    cnt_q;

    logic              a_sgn_c, b_sgn_c, a_neg_c, b_neg_c, neg_d;
    logic [XLEN-1:0]   mag_a_c, mag_b_c;
    logic [XLEN:0]     sum_c, shifted_c;
    logic [XLEN-1:0]   acc_n_c, lo_n_c;
    logic [2*XLEN-1:0] prod_c, prod_s_c;
    logic [XLEN-1:0]   dres_c, dres_s_c, md_res_c;

    // Operands are reduced to magnitudes; the sign is reapplied when the result is written.
    always_comb begin
        a_sgn_c = (OP[2:0] == 3'b001) || (OP[2:0] == 3'b010) ||
                  (OP[2:0] == 3'b100) || (OP[2:0] == 3'b110);
        b_sgn_c = (OP[2:0] == 3'b001) || (OP[2:0] == 3'b100) || (OP[2:0] == 3'b110);
        a_neg_c = a_sgn_c && RD1[XLEN-1];
        b_neg_c = b_sgn_c && RD2[XLEN-1];
        mag_a_c = a_neg_c ? -RD1 : RD1;
        mag_b_c = b_neg_c ? -RD2 : RD2;
        neg_d   = (OP[2] && OP[1]) ? a_neg_c : (a_neg_c ^ b_neg_c);
    end

    // One shift-add or restoring-subtract step per cycle.
    always_comb begin
        sum_c     = {1'b0, acc_q} + {1'b0, (lo_q[0] ? mcand_q : {XLEN{1'b0}})};
        shifted_c = {acc_q, lo_q[XLEN-1]};
        if (!mop_q[2]) begin
            acc_n_c = sum_c[XLEN:1];
            lo_n_c  = {sum_c[0], lo_q[XLEN-1:1]};
        end else if (shifted_c >= {1'b0, mcand_q}) begin
            acc_n_c = XLEN'(shifted_c - {1'b0, mcand_q});
            lo_n_c  = {lo_q[XLEN-2:0], 1'b1};
        end else begin
            acc_n_c = shifted_c[XLEN-1:0];
            lo_n_c  = {lo_q[XLEN-2:0], 1'b0};
        end
    end

    always_comb begin
        prod_c   = {acc_n_c, lo_n_c};
        prod_s_c = neg_q ? -prod_c : prod_c;
        dres_c   = mop_q[1] ? acc_n_c : lo_n_c;
        dres_s_c = neg_q ? -dres_c : dres_c;
        case (mop_q)
            3'b000:                  md_res_c = prod_s_c[XLEN-1:0];
            3'b001, 3'b010, 3'b011:  md_res_c = prod_s_c[2*XLEN-1:XLEN];
            default: begin
                if (div0_q) md_res_c = mop_q[1] ? aorig_q : {XLEN{1'b1}};
                else        md_res_c = dres_s_c;
            end
        endcase
    end
`endif

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            wd_q    <= '0;
            err_q   <= 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
            mop_q   <= '0;
            neg_q   <= 1'b0;
            div0_q  <= 1'b0;
            aorig_q <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
`endif
        end else if (accept_c) begin
`ifdef SEQ_ALU_MULDIV_EN
            if (MD) begin
                state_q <= S_BUSY;
                valid_q <= 1'b0;
                mop_q   <= OP[2:0];
                neg_q   <= neg_d;
                div0_q  <= (RD2 == '0);
                aorig_q <= RD1;
                acc_q   <= '0;
                lo_q    <= mag_a_c;
                mcand_q <= mag_b_c;
                cnt_q   <= '0;
            end else begin
                state_q <= S_DONE;
                valid_q <= 1'b1;
                wd_q    <= alu_res_c;
                err_q   <= alu_err_c;
            end
`else
            state_q <= S_DONE;
            valid_q <= 1'b1;
            wd_q    <= MD ? '0 : alu_res_c;
            err_q   <= MD | alu_err_c;
`endif
        end else begin
            case (state_q)
                S_BUSY: begin
`ifdef SEQ_ALU_MULDIV_EN
                    acc_q <= acc_n_c;
                    lo_q  <= lo_n_c;
                    cnt_q <= cnt_q + SHW'(1);
                    if (cnt_q == SHW'(XLEN - 1)) begin
                        state_q <= S_DONE;
                        valid_q <= 1'b1;
                        wd_q    <= md_res_c;
                        err_q   <= 1'b0;
                    end
`else
                    state_q <= S_IDLE;
`endif
                end
                S_DONE: begin
                    if (OUT_READY) begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu (XLEN=32); expectations follow SEQ_ALU_MULDIV_EN.
module tb_seq_alu;
    localparam int unsigned XLEN = 32;
`ifdef SEQ_ALU_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic            CLK;
    logic            RSTn;
    logic            IN_VALID;
    logic            IN_READY;
    logic [XLEN-1:0] RD1;
    logic [XLEN-1:0] RD2;
    logic [3:0]      OP;
    logic            MD;
    logic            OUT_VALID;
    logic            OUT_READY;
    logic [XLEN-1:0] WD;
    logic            ERR;

    int n_cmp = 0;
    int n_bad = 0;

    seq_alu #(.XLEN(XLEN)) dut (
        .CLK(CLK), .RSTn(RSTn), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .RD1(RD1), .RD2(RD2), .OP(OP), .MD(MD), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .WD(WD), .ERR(ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        string       name;
        logic        md;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] wd;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    function automatic vec_t av(input string n, input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] wd, input logic err);
        vec_t v;
        v.name = n; v.md = 1'b0; v.op = op; v.a = a; v.b = b;
        v.wd = wd; v.err = err; v.lat = 1;
        return v;
    endfunction

    function automatic vec_t mv(input string n, input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] wd);
        vec_t v;
        v.name = n; v.md = 1'b1; v.op = {1'b0, op}; v.a = a; v.b = b;
        v.wd  = MD_EN ? wd : 32'h0;
        v.err = !MD_EN;
        v.lat = MD_EN ? int'(XLEN) + 1 : 1;
        return v;
    endfunction

    // Present one op, hold it for the accepting edge, then scramble the inputs.
    task automatic issue(input logic md, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        for (int i = 0; i < 100 && !IN_READY; i++) @(negedge CLK);
        IN_VALID = 1'b1; MD = md; OP = op; RD1 = a; RD2 = b;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        RD1 = $urandom; RD2 = $urandom; OP = 4'($urandom); MD = 1'($urandom);
    endtask

    task automatic wait_valid(output int lat, output bit rdy_seen);
        lat = 0;
        rdy_seen = 1'b0;
        while (lat < 200) begin
            @(negedge CLK);
            lat++;
            if (OUT_VALID) break;
            if (IN_READY) rdy_seen = 1'b1;
        end
    endtask

    task automatic consume();
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
    endtask

    initial begin
        int lat;
        bit rdy;
        int hits;

        RSTn = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
        RD1 = '0; RD2 = '0; OP = '0; MD = 1'b0;

        vecs.push_back(av("add",      4'b0000, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0));
        vecs.push_back(av("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0));
        vecs.push_back(av("sub",      4'b1000, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0));
        vecs.push_back(av("sll",      4'b0001, 32'h0000_0003, 32'h0000_0024, 32'h0000_0030, 1'b0));
        vecs.push_back(av("slt",      4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0));
        vecs.push_back(av("sltu",     4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0));
        vecs.push_back(av("xor",      4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0));
        vecs.push_back(av("srl",      4'b0101, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b0));
        vecs.push_back(av("sra",      4'b1101, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0));
        vecs.push_back(av("or",       4'b0110, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0));
        vecs.push_back(av("and",      4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0));
        vecs.push_back(av("ill_1001", 4'b1001, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 1'b1));
        vecs.push_back(av("ill_1111", 4'b1111, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 1'b1));
        vecs.push_back(mv("mul",      3'b000, 32'h0000_0003, 32'h0000_0004, 32'h0000_000C));
        vecs.push_back(mv("mulh",     3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000));
        vecs.push_back(mv("mulhsu",   3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF));
        vecs.push_back(mv("mulhu",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE));
        vecs.push_back(mv("divu_0",   3'b101, 32'd100,       32'h0000_0000, 32'hFFFF_FFFF));
        vecs.push_back(mv("rem_0",    3'b110, 32'd7,         32'h0000_0000, 32'h0000_0007));
        vecs.push_back(mv("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000));
        vecs.push_back(mv("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000));
        vecs.push_back(mv("div_neg",  3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD));
        vecs.push_back(mv("rem_neg",  3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF));
        vecs.push_back(mv("divu",     3'b101, 32'd100,       32'd7,         32'd14));
        vecs.push_back(mv("remu",     3'b111, 32'd100,       32'd7,         32'd2));

        repeat (3) @(negedge CLK);
        check("rst_out_valid", 64'(OUT_VALID), 64'd0);
        check("rst_wd",        64'(WD),        64'd0);
        check("rst_err",       64'(ERR),       64'd0);
        RSTn = 1'b1;
        @(negedge CLK);
        check("rst_in_ready",  64'(IN_READY),  64'd1);

        foreach (vecs[i]) begin
            issue(vecs[i].md, vecs[i].op, vecs[i].a, vecs[i].b);
            wait_valid(lat, rdy);
            check({vecs[i].name, "_wd"},    64'(WD),  64'(vecs[i].wd));
            check({vecs[i].name, "_err"},   64'(ERR), 64'(vecs[i].err));
            check({vecs[i].name, "_lat"},   64'(lat), 64'(vecs[i].lat));
            check({vecs[i].name, "_ready"}, 64'(rdy), 64'd0);
            consume();
        end

        // Backpressure: result held, then a back-to-back ADD in the releasing cycle.
        issue(1'b0, 4'b1000, 32'd5, 32'd7);
        wait_valid(lat, rdy);
        check("bp_lat", 64'(lat), 64'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            check("bp_hold_wd",    64'(WD),        64'hFFFF_FFFE);
            check("bp_hold_valid", 64'(OUT_VALID), 64'd1);
            check("bp_hold_ready", 64'(IN_READY),  64'd0);
        end
        IN_VALID = 1'b1; MD = 1'b0; OP = 4'b0000; RD1 = 32'd1; RD2 = 32'd1; OUT_READY = 1'b1;
        #1;
        check("b2b_in_ready", 64'(IN_READY), 64'd1);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0; OUT_READY = 1'b0; RD1 = $urandom; RD2 = $urandom;
        @(negedge CLK);
        check("b2b_valid", 64'(OUT_VALID), 64'd1);
        check("b2b_wd",    64'(WD),        64'd2);
        check("b2b_err",   64'(ERR),       64'd0);
        consume();

        // Reset in the middle of a divide aborts it.
        issue(1'b1, 4'b0100, 32'd100, 32'd7);
        repeat (10) @(negedge CLK);
        #1;
        RSTn = 1'b0;
        #1;
        check("abort_valid", 64'(OUT_VALID), 64'd0);
        check("abort_wd",    64'(WD),        64'd0);
        check("abort_err",   64'(ERR),       64'd0);
        @(negedge CLK);
        RSTn = 1'b1;
        @(negedge CLK);
        check("abort_in_ready", 64'(IN_READY), 64'd1);
        hits = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (OUT_VALID) hits++;
        end
        check("abort_no_result", 64'(hits), 64'd0);
        issue(1'b0, 4'b0000, 32'd3, 32'd4);
        wait_valid(lat, rdy);
        check("post_abort_wd",  64'(WD),  64'd7);
        check("post_abort_lat", 64'(lat), 64'd1);
        consume();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
